// File: rtl/display_scan_if.sv
// Digit inputs, blink controls and active-low drive lines between the time-keeping logic and display_scan.
interface display_scan_if;
  logic [3:0] hour_g;
  logic [3:0] hour_d;
  logic [3:0] min_g;
  logic [3:0] min_d;
  logic       blink_hour;
  logic       blink_min;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hour_g, hour_d, min_g, min_d, blink_hour, blink_min,
    input  an, seg, dp
  );

  modport slave (
    input  hour_g, hour_d, min_g, min_d, blink_hour, blink_min,
    output an, seg, dp
  );
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame digit snapshot, set-mode blink and colon.
// Optional macro LEAD_ZERO_BLANK_EN blanks the hour tens digit while its snapshot is zero.
module display_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 512
) (
  input logic           _clk,
  input logic           reset,
  display_scan_if.slave dsp
);
  // state       | meaning
  // SLOT_MIN_D  | idx 0, minutes units on an[0]
  // SLOT_MIN_G  | idx 1, minutes tens on an[1]
  // SLOT_HOUR_D | idx 2, hours units on an[2], colon lit here
  // SLOT_HOUR_G | idx 3, hours tens on an[3]
  typedef enum logic [1:0] {
    SLOT_MIN_D  = 2'd0,
    SLOT_MIN_G  = 2'd1,
    SLOT_HOUR_D = 2'd2,
    SLOT_HOUR_G = 2'd3
  } slot_t;

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  slot_t         idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic          ph, ph_nx;
  logic [15:0]   snap, snap_nx;
  logic [3:0]    digit, an_sel, an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx, blank, dead;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Outputs are computed from the next (idx,cnt,ph) so the registered drive matches the slot it lands in.
  always_comb begin
    cnt_nx  = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nx  = (cnt == CNT_LAST) ? slot_t'(idx + 2'd1) : idx;
    bcnt_nx = (bcnt == BLINK_LAST) ? '0 : bcnt + 1'b1;
    ph_nx   = ph ^ (bcnt == BLINK_LAST);
    dead    = (cnt_nx == '0);

    snap_nx = snap;
    if (idx_nx == SLOT_MIN_D && dead)
      snap_nx = {dsp.hour_g, dsp.hour_d, dsp.min_g, dsp.min_d};

    case (idx_nx)
      SLOT_MIN_D:  begin digit = snap_nx[3:0];   an_sel = 4'b1110; end
      SLOT_MIN_G:  begin digit = snap_nx[7:4];   an_sel = 4'b1101; end
      SLOT_HOUR_D: begin digit = snap_nx[11:8];  an_sel = 4'b1011; end
      default:     begin digit = snap_nx[15:12]; an_sel = 4'b0111; end
    endcase

    if (idx_nx == SLOT_HOUR_D || idx_nx == SLOT_HOUR_G)
      blank = ph_nx && dsp.blink_hour;
    else
      blank = ph_nx && dsp.blink_min;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_nx == SLOT_HOUR_G && snap_nx[15:12] == 4'd0)
      blank = 1'b1;
`else
`endif

    an_nx  = (blank || dead) ? 4'b1111 : an_sel;
    seg_nx = blank ? 7'b1111111 : seg_decode(digit);
    dp_nx  = !(idx_nx == SLOT_HOUR_D && !dead && !ph_nx);
  end

  always_ff @(posedge _clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      idx     <= SLOT_MIN_D;
      bcnt    <= '0;
      ph      <= 1'b0;
      snap    <= '0;
      dsp.an  <= 4'b1111;
      dsp.seg <= 7'b1111111;
      dsp.dp  <= 1'b1;
    end else begin
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      bcnt    <= bcnt_nx;
      ph      <= ph_nx;
      snap    <= snap_nx;
      dsp.an  <= an_nx;
      dsp.seg <= seg_nx;
      dsp.dp  <= dp_nx;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: literal scan vectors, corner sequences and a random run against a cycle-index model.
module tb_display_scan;
  localparam int S0 = 4, B0 = 512;
  localparam int S1 = 3, B1 = 8;
  localparam logic [11:0] M_ALL = 12'hFFF;
  localparam logic [11:0] M_ANDP = {4'hF, 7'h00, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] h_g, h_d, m_g, m_d;
  logic bh, bm;
  int t;
  int vectors = 0;
  int miscompares = 0;
  logic [17:0] hist [0:8191];

  display_scan_if bus0 ();
  display_scan_if bus1 ();

  assign bus0.hour_g = h_g;  assign bus1.hour_g = h_g;
  assign bus0.hour_d = h_d;  assign bus1.hour_d = h_d;
  assign bus0.min_g  = m_g;  assign bus1.min_g  = m_g;
  assign bus0.min_d  = m_d;  assign bus1.min_d  = m_d;
  assign bus0.blink_hour = bh;  assign bus1.blink_hour = bh;
  assign bus0.blink_min  = bm;  assign bus1.blink_min  = bm;

  display_scan #(.SCAN_DIV(S0), .BLINK_DIV(B0)) u0 (._clk(clk), .reset(reset), .dsp(bus0.slave));
  display_scan #(.SCAN_DIV(S1), .BLINK_DIV(B1)) u1 (._clk(clk), .reset(reset), .dsp(bus1.slave));

  logic [11:0] o0, o1;
  assign o0 = {bus0.an, bus0.seg, bus0.dp};
  assign o1 = {bus1.an, bus1.seg, bus1.dp};

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0d", t);
    $fatal(1);
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an,seg,dp} at cycle tt after reset release, from slot/frame arithmetic.
  function automatic logic [11:0] model(input int s, input int b, input int tt);
    int cnt, idx, ph, f;
    logic [17:0] sn, lv;
    logic [3:0] dg, an;
    logic [6:0] sg;
    logic blank, dp;
    if (tt == 0) return {4'hF, 7'h7F, 1'b1};
    cnt = tt % s;
    idx = (tt / s) % 4;
    ph  = (tt / b) % 2;
    f   = tt / (4 * s);
    sn  = (f == 0) ? 18'd0 : hist[4 * s * f - 1];
    lv  = hist[tt - 1];
    case (idx)
      0: dg = sn[5:2];
      1: dg = sn[9:6];
      2: dg = sn[13:10];
      default: dg = sn[17:14];
    endcase
    blank = (ph == 1) && ((idx >= 2) ? lv[1] : lv[0]);
`ifdef LEAD_ZERO_BLANK_EN
    if (idx == 3 && sn[17:14] == 4'd0) blank = 1'b1;
`endif
    an = (blank || cnt == 0) ? 4'hF : ~(4'b0001 << idx);
    sg = blank ? 7'h7F : seg_ref(dg);
    dp = !(idx == 2 && cnt != 0 && ph == 0);
    return {an, sg, dp};
  endfunction

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp, input logic [11:0] mask);
    vectors++;
    if ((act & mask) !== (exp & mask)) begin
      miscompares++;
      $display("FAIL %s t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b (mask %h)",
               name, t, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], mask);
    end
  endtask

  task automatic check_model();
    cmp("model_u0", o0, model(S0, B0, t), M_ALL);
    cmp("model_u1", o1, model(S1, B1, t), M_ALL);
  endtask

  task automatic tick();
    hist[t] = {h_g, h_d, m_g, m_d, bh, bm};
    @(posedge clk);
    t++;
    @(negedge clk);
    check_model();
  endtask

  task automatic run_until(input int target);
    while (t < target) tick();
  endtask

  typedef struct {
    int          cyc;
    logic [11:0] exp;
    logic [11:0] mask;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{2,  {4'b1110, 7'b1000000, 1'b1}, M_ALL};
    tbl[1] = '{6,  {4'b1101, 7'b1000000, 1'b1}, M_ALL};
    tbl[2] = '{10, {4'b1011, 7'b1000000, 1'b0}, M_ALL};
    tbl[3] = '{14, {4'b0111, 7'b1000000, 1'b1}, M_ALL};
    tbl[4] = '{16, {4'b1111, 7'b0000000, 1'b1}, M_ANDP};
    tbl[5] = '{17, {4'b1110, 7'b0011001, 1'b1}, M_ALL};
    tbl[6] = '{22, {4'b1101, 7'b0110000, 1'b1}, M_ALL};
    tbl[7] = '{25, {4'b1011, 7'b0100100, 1'b0}, M_ALL};
    tbl[8] = '{31, {4'b0111, 7'b1111001, 1'b1}, M_ALL};

    h_g = 4'd1; h_d = 4'd2; m_g = 4'd3; m_d = 4'd4; bh = 1'b0; bm = 1'b0;
    t = 0;
    repeat (3) @(negedge clk);
    cmp("reset_state_u0", o0, {4'hF, 7'h7F, 1'b1}, M_ALL);
    reset = 1'b1;
    check_model();

    // basic 12:34 scan from reset release
    for (int i = 0; i < 9; i++) begin
      run_until(tbl[i].cyc);
      cmp($sformatf("scan_c%0d", tbl[i].cyc), o0, tbl[i].exp, tbl[i].mask);
    end

    // invalid BCD on min_d shows a dash in the following frame only on slot 0
    run_until(40);
    m_d = 4'hC;
    run_until(49);
    cmp("invalid_bcd_slot0", o0, {4'b1110, 7'b0111111, 1'b1}, M_ALL);
    run_until(53);
    cmp("invalid_bcd_slot1", o0, {4'b1101, 7'b0110000, 1'b1}, M_ALL);
    run_until(57);
    cmp("invalid_bcd_slot2", o0, {4'b1011, 7'b0100100, 1'b0}, M_ALL);
    m_d = 4'd4;

    // hour_d changed while idx==1 is held off until the next frame
    run_until(60);
    h_d = 4'd3;
    run_until(69);
    h_d = 4'd5;
    run_until(73);
    cmp("midframe_old", o0, {4'b1011, 7'b0110000, 1'b0}, M_ALL);
    run_until(89);
    cmp("midframe_new", o0, {4'b1011, 7'b0010010, 1'b0}, M_ALL);

    // hour tens zero
    h_g = 4'd0;
    run_until(109);
`ifdef LEAD_ZERO_BLANK_EN
    cmp("lead_zero", o0, {4'b1111, 7'b1111111, 1'b1}, M_ALL);
`else
    cmp("lead_zero", o0, {4'b0111, 7'b1000000, 1'b1}, M_ALL);
`endif
    h_g = 4'd1;

    // blink_hour on the fast-blink instance
    bh = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      if ((t / B1) % 2 == 1 && (t / S1) % 4 >= 2)
        cmp("blink_hour_blank", o1, {4'b1111, 7'b1111111, 1'b1}, M_ALL);
      else if ((t / B1) % 2 == 1 && t % S1 != 0)
        cmp("blink_min_shown", o1, {~(4'b0001 << ((t / S1) % 4)), 7'h00, 1'b1}, M_ANDP);
    end
    bh = 1'b0;

    // asynchronous reset at idx==2, cnt==2
    while (t % (4 * S0) != 2 * S0 + 2) tick();
    cmp("pre_reset_slot2", o0, {4'b1011, 7'h00, 1'b0}, M_ANDP);
    reset = 1'b0;
    #1;
    cmp("async_reset_u0", o0, {4'hF, 7'h7F, 1'b1}, M_ALL);
    cmp("async_reset_u1", o1, {4'hF, 7'h7F, 1'b1}, M_ALL);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    check_model();
    run_until(1);
    cmp("restart_idx0", o0, {4'b1110, 7'b1000000, 1'b1}, M_ALL);
    run_until(5);
    cmp("restart_idx1", o0, {4'b1101, 7'b1000000, 1'b1}, M_ALL);

    // random digits and blink controls
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [3:0] v;
        v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        case ($urandom_range(0, 3))
          0: h_g = v;
          1: h_d = v;
          2: m_g = v;
          default: m_d = v;
        endcase
      end
      if ($urandom_range(0, 63) == 0) bh = ~bh;
      if ($urandom_range(0, 63) == 0) bm = ~bm;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
